// File: rtl/counter_b4_seq.sv
// Command sequencer for a counter_b4: queues {mode, data, len, rco_stop}
// commands in a small FIFO and plays each one out as an enable run.
module counter_b4_seq #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     sq_clk,
    input  logic                     sq_reset,
    input  logic                     sq_cmd_valid,
    output logic                     sq_cmd_ready,
    input  logic [1:0]               sq_cmd_mode,
    input  logic [3:0]               sq_cmd_data,
    input  logic [3:0]               sq_cmd_len,
    input  logic                     sq_cmd_rco_stop,
    input  logic                     sq_halt,
    input  logic                     sq_rco,
    output logic                     sq_enable,
    output logic [1:0]               sq_mode,
    output logic [3:0]               sq_D,
    output logic                     sq_busy,
    output logic                     sq_done,
    output logic [$clog2(DEPTH):0]   sq_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned RW = 5;

    typedef struct packed {
        logic [1:0] mode;
        logic [3:0] data;
        logic [3:0] len;
        logic       rco_stop;
    } cmd_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    cmd_t            mem [DEPTH];
    cmd_t            cmd_in;
    cmd_t            head;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic            full;
    logic            push;
    logic            pop;

    state_t          state_q;
    state_t          state_d;
    logic [RW-1:0]   rem_q;
    logic [RW-1:0]   rem_d;
    logic [1:0]      mode_q;
    logic [1:0]      mode_d;
    logic [3:0]      d_q;
    logic [3:0]      d_d;
    logic            stop_q;
    logic            stop_d;
    logic            done_q;
    logic            done_d;
    logic            run_en;
    logic            can_issue;

    assign cmd_in = '{mode: sq_cmd_mode, data: sq_cmd_data,
                      len: sq_cmd_len, rco_stop: sq_cmd_rco_stop};
    assign head   = mem[rd_ptr_q];

    // Ready ignores a same-cycle pop, so a full FIFO never accepts.
    assign full         = (level_q == LW'(DEPTH));
    assign sq_cmd_ready = ~full & ~sq_reset;
    assign push         = sq_cmd_valid & sq_cmd_ready;

    assign run_en    = (state_q == RUN) & ~sq_halt;
    assign can_issue = (level_q != '0) & ~sq_halt;

    // FIFO storage: no reset needed, validity is tracked by level_q.
    always_ff @(posedge sq_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= cmd_in;
        end
    end

    always_ff @(posedge sq_clk or posedge sq_reset) begin
        if (sq_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge sq_clk or posedge sq_reset) begin
        if (sq_reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            mode_q  <= '0;
            d_q     <= '0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            d_q     <= d_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
        end
    end

    // Next state: issue from IDLE, count down enabled cycles in RUN,
    // and chain the next command at the completing edge when possible.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        d_d     = d_q;
        stop_d  = stop_q;
        done_d  = 1'b0;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (can_issue) begin
                    pop     = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (run_en) begin
                    if ((rem_q == RW'(1)) || (stop_q && sq_rco)) begin
                        done_d = 1'b1;
                        if (can_issue) begin
                            pop = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        rem_d = rem_q - RW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            rem_d  = (head.len == 4'd0) ? RW'(16) : {1'b0, head.len};
            mode_d = head.mode;
            d_d    = head.data;
            stop_d = head.rco_stop;
        end
    end

    assign sq_busy   = (state_q == RUN);
    assign sq_enable = sq_busy & ~sq_halt;
    assign sq_mode   = mode_q;
    assign sq_D      = d_q;
    assign sq_done   = done_q;
    assign sq_level  = level_q;

endmodule

// File: tb/tb_counter_b4_seq.sv
// Bench for counter_b4_seq: directed scenarios plus random traffic, all
// checked cycle by cycle against a command-queue reference model.
module tb_counter_b4_seq;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [1:0] mode;
        logic [3:0] data;
        logic [3:0] len;
        logic       stop;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic       ready;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_data;
    logic [3:0] cmd_len;
    logic       cmd_stop;
    logic       halt;
    logic       rco;
    logic       enable;
    logic [1:0] mode;
    logic [3:0] dval;
    logic       busy;
    logic       done;
    logic [2:0] level;

    counter_b4_seq #(.DEPTH(DEPTH)) dut (
        .sq_clk          (clk),
        .sq_reset        (rst),
        .sq_cmd_valid    (valid),
        .sq_cmd_ready    (ready),
        .sq_cmd_mode     (cmd_mode),
        .sq_cmd_data     (cmd_data),
        .sq_cmd_len      (cmd_len),
        .sq_cmd_rco_stop (cmd_stop),
        .sq_halt         (halt),
        .sq_rco          (rco),
        .sq_enable       (enable),
        .sq_mode         (mode),
        .sq_D            (dval),
        .sq_busy         (busy),
        .sq_done         (done),
        .sq_level        (level)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a queue of pending commands plus the active run.
    cmd_t       mq[$];
    bit         m_active;
    int         m_left;
    bit         m_stop;
    logic [1:0] m_mode;
    logic [3:0] m_data;
    bit         m_done;
    bit         m_push;
    cmd_t       m_in;

    int step_no, en_cnt, done_cnt, first_en, done_step;
    bit ready_low, acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    function automatic cmd_t mk(input logic [1:0] m, input logic [3:0] d,
                                input logic [3:0] l, input logic s);
        cmd_t c;
        c.mode = m; c.data = d; c.len = l; c.stop = s;
        return c;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_active = 0; m_left = 0; m_stop = 0;
        m_mode = '0; m_data = '0; m_done = 0;
    endtask

    task automatic model_edge();
        bit fin;
        cmd_t c;
        fin = 0;
        if (m_active && !halt) begin
            m_left--;
            if (m_left == 0 || (m_stop && rco)) begin
                fin = 1;
                m_active = 0;
            end
        end
        if (!m_active && mq.size() > 0 && !halt) begin
            c = mq.pop_front();
            m_active = 1;
            m_left   = (c.len == 0) ? 16 : int'(c.len);
            m_stop   = c.stop;
            m_mode   = c.mode;
            m_data   = c.data;
        end
        if (m_push) mq.push_back(m_in);
        m_done = fin;
    endtask

    task automatic compare_all();
        check("ready",  32'(ready),  32'(!rst && mq.size() < DEPTH));
        check("level",  32'(level),  32'(mq.size()));
        check("busy",   32'(busy),   32'(m_active));
        check("enable", 32'(enable), 32'(m_active && !halt));
        check("mode",   32'(mode),   32'(m_mode));
        check("D",      32'(dval),   32'(m_data));
        check("done",   32'(done),   32'(m_done));
    endtask

    task automatic clear_counts();
        step_no = 0; en_cnt = 0; done_cnt = 0;
        first_en = -1; done_step = -1; ready_low = 0;
    endtask

    // One clock cycle: drive at negedge, check, then advance the model at posedge.
    task automatic step(input logic v, input cmd_t c, input logic h, input logic r);
        @(negedge clk);
        valid = v; cmd_mode = c.mode; cmd_data = c.data;
        cmd_len = c.len; cmd_stop = c.stop; halt = h; rco = r;
        #1;
        compare_all();
        if (enable) begin
            en_cnt++;
            if (first_en < 0) first_en = step_no;
        end
        if (done) begin
            done_cnt++;
            done_step = step_no;
        end
        if (!ready) ready_low = 1;
        acc    = v && ready;
        m_push = v && (mq.size() < DEPTH);
        m_in   = c;
        @(posedge clk);
        model_edge();
        step_no++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, mk(2'd0, 4'd0, 4'd0, 1'b0), 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid = 0; halt = 0; rco = 0;
        rst = 1;
        model_reset();
        #1;
        compare_all();
        check("rst_enable", 32'(enable), 32'd0);
        check("rst_ready",  32'(ready),  32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        check("ready_after_rst", 32'(ready), 32'd1);
    endtask

    initial begin
        rst = 1; valid = 0; halt = 0; rco = 0;
        cmd_mode = '0; cmd_data = '0; cmd_len = '0; cmd_stop = 0;
        model_reset();
        do_reset();

        // Single command into an idle block.
        clear_counts();
        step(1'b1, mk(2'd3, 4'hA, 4'd3, 1'b0), 1'b0, 1'b0);
        idle(8);
        check("single_en_cnt", 32'(en_cnt), 32'd3);
        check("single_first", 32'(first_en), 32'd2);
        check("single_done", 32'(done_cnt), 32'd1);

        // Five back-to-back pushes overflow a 4-deep FIFO.
        clear_counts();
        for (int k = 0; k < 5; k++) begin
            int tries;
            tries = 0;
            acc = 0;
            while (!acc && tries < 40) begin
                step(1'b1, mk(2'(k), 4'(k + 5), 4'd4, 1'b0), 1'b0, 1'b0);
                tries++;
            end
            check("b2b_accepted", 32'(acc), 32'd1);
        end
        idle(30);
        check("b2b_ready_low", 32'(ready_low), 32'd1);
        check("b2b_en_cnt", 32'(en_cnt), 32'd20);
        check("b2b_done", 32'(done_cnt), 32'd5);

        // len = 0 means a 16-cycle run.
        clear_counts();
        step(1'b1, mk(2'd1, 4'h3, 4'd0, 1'b0), 1'b0, 1'b0);
        idle(22);
        check("len16_en_cnt", 32'(en_cnt), 32'd16);
        check("len16_done", 32'(done_cnt), 32'd1);

        // rco-stop on the 4th enabled cycle of a len=10 run.
        clear_counts();
        step(1'b1, mk(2'd2, 4'h7, 4'd10, 1'b1), 1'b0, 1'b0);
        for (int i = 1; i < 16; i++) step(1'b0, mk(2'd0, 4'd0, 4'd0, 1'b0), 1'b0, 1'(i == 5));
        check("rco_en_cnt", 32'(en_cnt), 32'd4);
        check("rco_done_step", 32'(done_step), 32'd6);
        check("rco_done", 32'(done_cnt), 32'd1);

        // Halt for run cycles 2-3 of a len=4 run.
        clear_counts();
        step(1'b1, mk(2'd1, 4'hC, 4'd4, 1'b0), 1'b0, 1'b0);
        for (int i = 1; i < 12; i++) step(1'b0, mk(2'd0, 4'd0, 4'd0, 1'b0), 1'(i == 3 || i == 4), 1'b0);
        check("halt_en_cnt", 32'(en_cnt), 32'd4);
        check("halt_done_step", 32'(done_step), 32'd8);

        // Halt while idle with two queued commands blocks issue.
        clear_counts();
        step(1'b1, mk(2'd2, 4'h1, 4'd1, 1'b0), 1'b1, 1'b0);
        step(1'b1, mk(2'd3, 4'h2, 4'd1, 1'b0), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, mk(2'd0, 4'd0, 4'd0, 1'b0), 1'b1, 1'b0);
        check("halt_idle_level", 32'(level), 32'd2);
        check("halt_idle_busy", 32'(busy), 32'd0);
        idle(6);
        check("halt_release_done", 32'(done_cnt), 32'd2);

        // Reset in the middle of a len=8 run after 3 enabled cycles.
        clear_counts();
        step(1'b1, mk(2'd3, 4'hF, 4'd8, 1'b0), 1'b0, 1'b0);
        idle(4);
        check("pre_rst_en_cnt", 32'(en_cnt), 32'd3);
        do_reset();
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        clear_counts();
        idle(4);
        check("rst_no_done", 32'(done_cnt), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)),
                     mk(2'($urandom), 4'($urandom), 4'($urandom_range(0, 5)), 1'($urandom_range(0, 1))),
                     1'($urandom_range(0, 7) == 0),
                     1'($urandom_range(0, 5) == 0));
            end
        end
        idle(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_b4_seq.md
# counter_b4_seq

Command sequencer for one counter_b4 instance. It accepts {mode, data, run-length} commands through a valid/ready port into a small FIFO, then drives the counter's enable, mode and D inputs for the commanded number of clock cycles. A run can optionally terminate early on the counter's ripple-carry output. It sits between the test/control logic and the counter so that software-style command lists replace hand-toggled control pins.

## Interface

**Parameters**
- DEPTH, default 4: command FIFO entries; power of two, minimum 2.

**Ports**
- sq_clk, in, 1: single clock; all state updates on its rising edge.
- sq_reset, in, 1: asynchronous, active-high reset.
- sq_cmd_valid, in, 1: a command is present on sq_cmd_*.
- sq_cmd_ready, out, 1: FIFO can accept; equals not-full AND not sq_reset.
- sq_cmd_mode, in, 2: mode value to present to the counter.
- sq_cmd_data, in, 4: D value to present to the counter.
- sq_cmd_len, in, 4: run length in enabled cycles, 1..15; a value of 0 means 16.
- sq_cmd_rco_stop, in, 1: end the run early when sq_rco is seen.
- sq_halt, in, 1: pause; freezes the run and blocks issue.
- sq_rco, in, 1: counter ripple-carry (b4_rco).
- sq_enable, out, 1: to b4_enable.
- sq_mode, out, 2: to b4_mode.
- sq_D, out, 4: to b4_D.
- sq_busy, out, 1: a command is executing.
- sq_done, out, 1: one-cycle pulse at command completion.
- sq_level, out, log2(DEPTH)+1: FIFO occupancy, 0..DEPTH.

## Operation

**Reset.** While sq_reset is high, all of the following hold: FIFO empty, state IDLE, and sq_enable, sq_mode, sq_D, sq_busy, sq_done, sq_level and sq_cmd_ready are all 0. Assertion of reset mid-run aborts the run immediately, with no sq_done pulse.

**Push.** A command is written when sq_cmd_valid and sq_cmd_ready are both high at an edge. sq_cmd_ready does not depend on a same-cycle pop, so no push occurs when the FIFO is full, even if a pop happens in that cycle.

**FSM states.**
- IDLE: sq_busy is 0 and sq_enable is 0. sq_mode and sq_D hold the last issued values (0 after reset).
  - If level > 0 and sq_halt is low: pop the head, register mode, D and remaining = len (0 maps to 16), then go to RUN.
- RUN: sq_busy is 1. sq_enable is high exactly when sq_halt is low (combinational gate of a registered run flag).
  - Each edge with sq_enable high decrements remaining.
  - The run ends at the edge where remaining == 1 with sq_enable high, or where sq_cmd_rco_stop was set for the command, sq_rco is 1 and sq_enable is high.
  - At the end of a run: sq_done is registered high for the next cycle. If level > 0 and sq_halt is low, pop the next command at the same edge and stay in RUN (back-to-back). Otherwise go to IDLE.
- Halt in RUN: remaining is frozen and sq_rco is ignored. sq_mode and sq_D stay stable.

**Arithmetic.** remaining is a 5-bit register. The FIFO pointers wrap modulo DEPTH. Simultaneous push and pop leaves sq_level unchanged.

## Timing

- Command latency into an empty, idle block:
  - Push at edge E0, so sq_level = 1 after E0.
  - Pop at E1, so sq_enable, sq_mode and sq_D are valid after E1.
- A run of length L with no halt holds sq_enable high for exactly L consecutive cycles.
- sq_done is high in the single cycle after the final enabled cycle.
- Back-to-back commands: the next command's sq_enable, sq_mode and sq_D appear in the same cycle as sq_done, with zero bubble.
- An rco-stop run ends in the cycle in which sq_rco is sampled high; that cycle counts as enabled.
- A halt asserted for H cycles extends the run by exactly H cycles.
- sq_busy falls in the cycle sq_done is high, unless a back-to-back command issues.

## Test plan

- Reset mid-run (len=8, after 3 enabled cycles): all outputs read 0 immediately, sq_level=0, no sq_done pulse, and sq_cmd_ready=1 after reset release.
- Single command {mode=3, data=4'hA, len=3} into an idle block: sq_enable is high for 3 cycles starting 2 edges after the push, sq_mode=3 and sq_D=A throughout, then sq_done pulses once.
- Push 5 commands back-to-back with DEPTH=4 while the first is executing:
  - sq_cmd_ready drops when sq_level=4.
  - Runs execute in order with no enable gap between them.
  - sq_done pulses once per command.
- Command {len=0, rco_stop=0}: sq_enable is high for exactly 16 cycles.
- Command {len=10, rco_stop=1} with sq_rco pulsed on the 4th enabled cycle: the run ends after 4 enabled cycles and sq_done follows.
- Command {len=4} with sq_halt high for cycles 2–3 of the run:
  - sq_enable is low for those 2 cycles; total enabled cycles = 4 and completion is delayed by 2 cycles.
  - Halt high while idle with sq_level=2: no issue until halt drops.
